// File: rtl/uart_rx_decoder.sv
// uart_rx_decoder: 8N1 UART receiver with a 2-FF synchronizer, 3-sample mid-bit majority vote,
// a valid/ready holding register, and framing-error / overrun pulses.
// Ports:
//   i_clk12       sole clock
//   i_reset       synchronous active-high reset
//   i_rx          asynchronous serial line, idle high
//   o_rx_data     received byte, valid while o_rx_valid=1
//   o_rx_valid    byte available in the holding register
//   i_rx_ready    consumer takes the byte when o_rx_valid && i_rx_ready at an edge
//   o_frame_err   one-cycle pulse: stop bit sampled low
//   o_overrun     one-cycle pulse: completed byte dropped because the holding register was full
//   o_busy        receiver not idle
//   o_frame_count bytes delivered to the holding register, wraps
module uart_rx_decoder #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        i_clk12,
    input  logic        i_reset,
    input  logic        i_rx,
    output logic [7:0]  o_rx_data,
    output logic        o_rx_valid,
    input  logic        i_rx_ready,
    output logic        o_frame_err,
    output logic        o_overrun,
    output logic        o_busy,
    output logic [15:0] o_frame_count
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        r_state, w_next;
    logic          r_s1, r_rx_s;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [1:0]    r_smp;
    logic [7:0]    r_shift;
    logic          r_done, r_ferr;
    logic          w_dec, w_end, w_maj;

    always_ff @(posedge i_clk12) begin
        r_state <= i_reset ? IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = r_rx_s ? IDLE : START;
            START:   w_next = (w_dec && w_maj) ? IDLE : w_end ? DATA : START;
            DATA:    w_next = (w_end && r_bit == 3'd7) ? STOP : DATA;
            STOP:    w_next = w_dec ? (w_maj ? IDLE : BREAK) : STOP;
            BREAK:   w_next = r_rx_s ? IDLE : BREAK;
            default: w_next = IDLE;
        endcase
    end

    // r_cnt trails the line-cycle index of the current bit by one: the value of r_rx_s seen
    // at the edge where r_cnt==c is line cycle c+1 of the bit. So the samples taken at
    // r_cnt==H-2, H-1 and the live r_rx_s at r_cnt==H are line cycles H-1, H, H+1.
    always_comb begin
        w_dec = r_cnt == CW'(H);
        w_end = r_cnt == CW'(CLKS_PER_BIT - 1);
        w_maj = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rx_s) | (r_smp[1] & r_rx_s);
    end

    always_ff @(posedge i_clk12) begin
        if (i_reset) begin
            r_s1          <= 1'b1;
            r_rx_s        <= 1'b1;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_smp         <= '0;
            r_shift       <= '0;
            r_done        <= 1'b0;
            r_ferr        <= 1'b0;
            o_rx_data     <= '0;
            o_rx_valid    <= 1'b0;
            o_frame_err   <= 1'b0;
            o_overrun     <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_count <= '0;
        end else begin
            r_s1   <= i_rx;
            r_rx_s <= r_s1;
            r_cnt  <= (r_state == IDLE || w_end) ? '0 : r_cnt + 1'b1;
            if (r_cnt == CW'(H - 2)) r_smp[0] <= r_rx_s;
            if (r_cnt == CW'(H - 1)) r_smp[1] <= r_rx_s;
            if (r_state == START) r_bit <= '0;
            else if (r_state == DATA && w_end) r_bit <= r_bit + 1'b1;
            if (r_state == DATA && w_dec) r_shift <= {w_maj, r_shift[7:1]};
            // Stop-bit outcome is staged one cycle so delivery and error land on the same edge.
            r_done      <= r_state == STOP && w_dec && w_maj;
            r_ferr      <= r_state == STOP && w_dec && !w_maj;
            o_busy      <= w_next != IDLE;
            o_frame_err <= r_ferr;
            o_overrun   <= r_done && o_rx_valid && !i_rx_ready;
            if (r_done && (!o_rx_valid || i_rx_ready)) begin
                o_rx_data     <= r_shift;
                o_rx_valid    <= 1'b1;
                o_frame_count <= o_frame_count + 1'b1;
            end else if (o_rx_valid && i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/uart_rx_decoder.md
Name: uart_rx_decoder

Overview:
- Synthesizable 8N1 UART receiver: the far end of the SoC's serial_tx line.
- Used in the FPGA sim harness and CI to decode console bytes from cram_fpga into a byte stream with valid/ready handshake.
- Reports framing errors and overruns.
- Samples an asynchronous line with a 2-FF synchronizer and 3-sample majority vote at mid-bit.

Parameters:
CLKS_PER_BIT, 104, clk12 cycles per bit (12 MHz / 115200); must be >= 8.
H (localparam), CLKS_PER_BIT/2 (integer division), mid-bit offset.

Ports:
clk12  input  1  sole clock
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
rx_data  output  8  received byte, valid while rx_valid=1
rx_valid  output  1  byte available
rx_ready  input  1  consumer accepts byte when rx_valid&&rx_ready at a clk12 edge
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped because holding register full
busy  output  1  high in any state other than IDLE
frame_count  output  16  count of bytes delivered to holding register, wraps 0xFFFF->0

Behaviour:
- Reset values (synchronous): sync FFs=1, state=IDLE, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, frame_count=0, bit/cycle counters=0. Reset mid-frame abandons the frame; no partial byte or error is reported.
- Synchronizer: rx -> s1 -> rx_s. Pin-to-rx_s latency is 2 clocks. All logic uses rx_s.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: rx_s==0 at an edge -> START, cycle counter=0. Call this edge E0.
- Bit timing: bit k (0=start, 1..8=data LSB first, 9=stop) occupies counter values 0..CLKS_PER_BIT-1.
  - Samples are taken at counter H-1, H, H+1.
  - The majority of the 3 samples is the bit decision, made at edge E0 + k*CLKS_PER_BIT + H + 1.
- START decision:
  - Majority=1 -> false start; return to IDLE, no output.
  - Majority=0 -> continue to end of bit period, then DATA.
- DATA: shift decisions into the shift register LSB first. After 8 bits -> STOP at the bit boundary.
- STOP decision:
  - Majority=1 -> return to IDLE immediately (at the decision edge, not end of bit) to allow resync on back-to-back frames. Deliver byte.
  - Majority=0 -> frame_err=1 for exactly one cycle. Byte discarded, frame_count unchanged. Go to BREAK.
- BREAK: wait for rx_s==1, then IDLE. No events are generated in BREAK.
- Delivery (registered at edge after stop decision):
  - If rx_valid=0, or rx_valid&&rx_ready in that same cycle: rx_data<=byte, rx_valid<=1, frame_count+=1.
  - If rx_valid=1 and rx_ready=0: byte dropped, rx_data/rx_valid unchanged, overrun=1 for one cycle, frame_count unchanged.
- Handshake: rx_valid&&rx_ready with no simultaneous delivery -> rx_valid<=0 next edge. rx_data is held stable while rx_valid=1 and not accepted.
- Latency: rx_valid rises at edge E0 + 9*CLKS_PER_BIT + H + 2.
- busy: registered from the next state; 0 only in IDLE.
- A single-cycle glitch affecting one of the 3 samples does not change the bit decision.

Test Plan:
All tests use CLKS_PER_BIT=16, H=8.
1. Clean frame 0x55, rx_ready=1 -> rx_valid high at E0+154, rx_data=0x55, frame_count=1, frame_err=overrun=0.
2. rx low for 4 clocks then high (false start) -> no rx_valid, no frame_err; busy returns 0 by E0+10; a following 0x3C frame is received correctly.
3. Frame 0xA5 with stop bit 0, rx then held low 48 clocks (break) -> single frame_err pulse at E0+154, no rx_valid, no further pulses during low; after rx high, frame 0x3C is received with frame_count=1.
4. Frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x11 held, one overrun pulse at second delivery, frame_count=1. Assert rx_ready for 1 cycle -> rx_valid drops.
5. Back-to-back 0x00 then 0xFF with 0 idle cycles, rx_ready=1. Inject a 1-clock spike at counter H of data bit 3 in the first frame -> bytes 0x00, 0xFF delivered, frame_count=2. Repeat with delivery coinciding with acceptance of the prior byte -> rx_valid stays 1, new data loaded.
6. Assert reset for 1 cycle during data bit 4 -> all outputs at reset values next edge; the subsequent frame 0x81 is received correctly.
